// File: rtl/psimd_addsub.sv
// psimd_addsub: packed-SIMD signed add/subtract with optional per-lane saturation.
//
// Two-stage valid/ready pipeline. Stage 1 captures the operands and the
// per-beat controls; stage 2 holds the per-lane result, the overflow flags
// and the output valid bit. A single advance enable moves both stages
// together, so bubbles travel down the pipe exactly like data.
//
// Ports
//   clk         : clock, all state changes on the rising edge
//   rst         : synchronous active-high reset
//   in_valid    : operand beat present
//   in_ready    : block accepts a beat this cycle
//   a, b        : operands, lane i at bits [i*LANE_W +: LANE_W]
//   op_sub      : 0 = A+B, 1 = A-B (per lane), sampled with the beat
//   sat_en      : 1 = saturate overflowing lanes, 0 = wrap, sampled with the beat
//   out_valid   : result beat present
//   out_ready   : downstream accepts the result
//   result      : per-lane result
//   ovf         : per-lane overflow flags of the current result beat
//   sticky_ovf  : per-lane OR of ovf over all delivered beats since reset/clear
//   clr_sticky  : clears sticky_ovf (a simultaneous delivered overflow wins)
module psimd_addsub #(
    parameter int LANE_W = 4,
    parameter int LANES  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANE_W*LANES-1:0]  a,
    input  logic [LANE_W*LANES-1:0]  b,
    input  logic                     op_sub,
    input  logic                     sat_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANE_W*LANES-1:0]  result,
    output logic [LANES-1:0]         ovf,
    output logic [LANES-1:0]         sticky_ovf,
    input  logic                     clr_sticky
);

    localparam int W = LANE_W * LANES;

    // Stage 1 registers
    logic             s1_valid_reg;
    logic [W-1:0]     s1_a_reg;
    logic [W-1:0]     s1_b_reg;
    logic             s1_sub_reg;
    logic             s1_sat_reg;

    // Stage 2 registers
    logic             out_valid_reg;
    logic [W-1:0]     result_reg;
    logic [LANES-1:0] ovf_reg;
    logic [LANES-1:0] sticky_reg;

    // Combinational lane results computed from stage 1
    logic [W-1:0]     result_next;
    logic [LANES-1:0] ovf_next;

    logic adv;
    logic delivered;

    // Both stages advance together whenever the output slot is free or drains.
    assign adv       = !out_valid_reg || out_ready;
    assign delivered = out_valid_reg && out_ready;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [LANE_W-1:0] lane_a;
            logic [LANE_W-1:0] lane_b;
            logic [LANE_W-1:0] lane_raw;
            logic [LANE_W-1:0] lane_sat;
            logic              lane_ovf;
            logic              sign_a;
            logic              sign_b;
            logic              sign_r;

            assign lane_a   = s1_a_reg[gi*LANE_W +: LANE_W];
            assign lane_b   = s1_b_reg[gi*LANE_W +: LANE_W];
            assign lane_raw = s1_sub_reg ? (lane_a - lane_b) : (lane_a + lane_b);

            assign sign_a = lane_a[LANE_W-1];
            assign sign_b = lane_b[LANE_W-1];
            assign sign_r = lane_raw[LANE_W-1];

            // Add overflows only for like signs, subtract only for unlike signs;
            // in both cases the wrapped result has flipped away from A's sign.
            assign lane_ovf = (s1_sub_reg ? (sign_a != sign_b) : (sign_a == sign_b))
                              && (sign_r != sign_a);

            // Overflow always moves away from A's sign, so A picks the rail.
            assign lane_sat = sign_a ? {1'b1, {(LANE_W-1){1'b0}}}
                                     : {1'b0, {(LANE_W-1){1'b1}}};

            assign result_next[gi*LANE_W +: LANE_W] = (s1_sat_reg && lane_ovf) ? lane_sat
                                                                              : lane_raw;
            assign ovf_next[gi] = lane_ovf;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_a_reg      <= '0;
            s1_b_reg      <= '0;
            s1_sub_reg    <= 1'b0;
            s1_sat_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            ovf_reg       <= '0;
        end else if (adv) begin
            s1_valid_reg  <= in_valid;
            s1_a_reg      <= a;
            s1_b_reg      <= b;
            s1_sub_reg    <= op_sub;
            s1_sat_reg    <= sat_en;
            out_valid_reg <= s1_valid_reg;
            // Bubbles leave a clean zero result rather than stale lane data.
            result_reg    <= s1_valid_reg ? result_next : '0;
            ovf_reg       <= s1_valid_reg ? ovf_next : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_reg <= '0;
        end else if (clr_sticky) begin
            // Per lane: a flag set by a beat delivered this cycle survives the clear.
            sticky_reg <= delivered ? ovf_reg : '0;
        end else if (delivered) begin
            sticky_reg <= sticky_reg | ovf_reg;
        end
    end

    assign in_ready   = adv;
    assign out_valid  = out_valid_reg;
    assign result     = result_reg;
    assign ovf        = ovf_reg;
    assign sticky_ovf = sticky_reg;

endmodule

// File: tb/tb_psimd_addsub.sv
// Self-checking bench for psimd_addsub (LANE_W = 4, LANES = 4).
// A scoreboard of expected beats, computed with integer arithmetic from the
// lane rules, is filled on every accepted beat and drained on every delivery.
module tb_psimd_addsub;

    localparam int LW   = 4;
    localparam int LN   = 4;
    localparam int W    = LW * LN;
    localparam int MAXV = (1 << (LW - 1)) - 1;
    localparam int MINV = -(1 << (LW - 1));

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          op_sub = 1'b0;
    logic          sat_en = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic [LN-1:0] ovf;
    logic [LN-1:0] sticky_ovf;
    logic          clr_sticky = 1'b0;

    psimd_addsub #(.LANE_W(LW), .LANES(LN)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op_sub     (op_sub),
        .sat_en     (sat_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .ovf        (ovf),
        .sticky_ovf (sticky_ovf),
        .clr_sticky (clr_sticky)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0]  res;
        logic [LN-1:0] ov;
    } beat_t;

    // Reference: per lane, signed integer add/sub, then range check.
    function automatic beat_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                    input logic sub, input logic sat);
        beat_t r;
        int x, y, z;
        r.res = '0;
        r.ov  = '0;
        for (int i = 0; i < LN; i++) begin
            x = int'($signed(av[i*LW +: LW]));
            y = int'($signed(bv[i*LW +: LW]));
            z = sub ? (x - y) : (x + y);
            if (z > MAXV || z < MINV) begin
                r.ov[i] = 1'b1;
                if (sat) z = (z > MAXV) ? MAXV : MINV;
            end
            r.res[i*LW +: LW] = z[LW-1:0];
        end
        return r;
    endfunction

    beat_t         sb[$];
    logic [LN-1:0] sticky_model = '0;
    bit            stall_prev = 1'b0;
    logic [W-1:0]  res_prev = '0;
    logic [LN-1:0] ovf_prev = '0;

    // Compare process: sampled on the falling edge, where inputs and outputs
    // are stable and the handshakes of the coming rising edge are known.
    always @(negedge clk) begin
        beat_t e;
        bit    deliv;
        e.res = '0;
        e.ov  = '0;
        check("sticky", 32'(sticky_ovf), 32'(sticky_model));
        if (rst) begin
            sb.delete();
            sticky_model = '0;
            stall_prev   = 1'b0;
        end else begin
            check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (stall_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_result", 32'(result), 32'(res_prev));
                check("hold_ovf", 32'(ovf), 32'(ovf_prev));
            end
            if (out_valid && sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stale_beat: got result %0h with no beat outstanding", result);
            end
            deliv = out_valid && out_ready;
            if (deliv && sb.size() > 0) begin
                e = sb.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("ovf", 32'(ovf), 32'(e.ov));
                $display("deliver result=%04h ovf=%04b", result, ovf);
            end
            if (clr_sticky) sticky_model = deliv ? e.ov : '0;
            else if (deliv) sticky_model = sticky_model | e.ov;
            if (in_valid && in_ready) begin
                sb.push_back(model(a, b, op_sub, sat_en));
                $display("accept a=%04h b=%04h sub=%0d sat=%0d", a, b, op_sub, sat_en);
            end
            stall_prev = out_valid && !out_ready;
            res_prev   = result;
            ovf_prev   = ovf;
        end
    end

    // One beat through an empty pipe with out_ready held high; checks the
    // 2-cycle latency and the literal result.
    task automatic run_one(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic sub, input logic sat,
                           input logic [W-1:0] er, input logic [LN-1:0] eo,
                           input string nm);
        a = av; b = bv; op_sub = sub; sat_en = sat; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk) check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk) #1 in_valid = 1'b0;
        @(negedge clk) check({nm, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({nm, "_lat2"}, 32'(out_valid), 32'd1);
        check({nm, "_result"}, 32'(result), 32'(er));
        check({nm, "_ovf"}, 32'(ovf), 32'(eo));
        @(posedge clk) #1;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_sticky", 32'(sticky_ovf), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk) #1;

        // Directed beats with hand-computed results
        run_one(16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2345, 4'b0000, "add");
        run_one(16'h7FFF, 16'h1000, 1'b0, 1'b1, 16'h7FFF, 4'b1000, "add_sat");
        @(negedge clk) check("add_sat_sticky", 32'(sticky_ovf), 32'h8);
        @(posedge clk) #1;
        run_one(16'h7FFF, 16'h1000, 1'b0, 1'b0, 16'h8FFF, 4'b1000, "add_wrap");
        run_one(16'h8000, 16'h1001, 1'b1, 1'b1, 16'h800F, 4'b1000, "sub_sat");
        run_one(16'h8000, 16'h1001, 1'b1, 1'b0, 16'h700F, 4'b1000, "sub_wrap");

        // Plain clear, then a lane-0 overflow, then clear racing a lane-3 overflow
        clr_sticky = 1'b1;
        @(posedge clk) #1 clr_sticky = 1'b0;
        @(negedge clk) check("clr_plain", 32'(sticky_ovf), 32'h0);
        @(posedge clk) #1;
        run_one(16'h0007, 16'h0001, 1'b0, 1'b0, 16'h0008, 4'b0001, "lane0_ovf");
        @(negedge clk) check("lane0_sticky", 32'(sticky_ovf), 32'h1);
        @(posedge clk) #1;
        a = 16'h7FFF; b = 16'h1000; op_sub = 1'b0; sat_en = 1'b1; in_valid = 1'b1;
        @(posedge clk) #1 in_valid = 1'b0;
        @(posedge clk) #1 clr_sticky = 1'b1;
        @(negedge clk) check("clr_set_deliver", 32'(out_valid), 32'd1);
        @(posedge clk) #1 clr_sticky = 1'b0;
        @(negedge clk) check("clr_set_sticky", 32'(sticky_ovf), 32'h8);
        @(posedge clk) #1;

        // Backpressure: three beats offered, two accepted, then drained in order
        out_ready = 1'b0;
        a = 16'h1234; b = 16'h1111; op_sub = 1'b0; sat_en = 1'b1; in_valid = 1'b1;
        @(negedge clk) check("bp_rdy0", 32'(in_ready), 32'd1);
        @(posedge clk) #1 a = 16'h7FFF; b = 16'h1000;
        @(negedge clk) check("bp_rdy1", 32'(in_ready), 32'd1);
        @(posedge clk) #1 a = 16'h8000; b = 16'h1001; op_sub = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_stall_rdy", 32'(in_ready), 32'd0);
            check("bp_stall_result", 32'(result), 32'h2345);
        end
        @(posedge clk) #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_d1_valid", 32'(out_valid), 32'd1);
        check("bp_d1_result", 32'(result), 32'h2345);
        @(posedge clk) #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_d2_result", 32'(result), 32'h7FFF);
        check("bp_d2_ovf", 32'(ovf), 32'h8);
        @(negedge clk);
        check("bp_d3_result", 32'(result), 32'h800F);
        @(posedge clk) #1;

        // Reset with two beats in flight
        out_ready = 1'b0;
        a = 16'h0101; b = 16'h0202; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk) #1 a = 16'h7070;
        @(posedge clk) #1 in_valid = 1'b0; rst = 1'b1;
        @(posedge clk) #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_sticky", 32'(sticky_ovf), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) check("rst_no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk) #1;

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 800; i++) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            a          = W'($urandom);
            b          = W'($urandom);
            op_sub     = 1'($urandom_range(0, 1));
            sat_en     = 1'($urandom_range(0, 1));
            out_ready  = ($urandom_range(0, 9) < 7);
            clr_sticky = ($urandom_range(0, 19) == 0);
            @(posedge clk) #1;
        end
        in_valid = 1'b0; clr_sticky = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psimd_addsub.md
PSIMD_ADDSUB -- requirements
Module: psimd_addsub

Interface
REQ-001 SHALL have parameter LANE_W, default 4, bit width of one signed lane.
REQ-002 SHALL have parameter LANES, default 4, number of lanes; data width W = LANE_W*LANES.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-007 SHALL have port a  input  W  operand A, lane i at bits [i*LANE_W +: LANE_W].
REQ-008 SHALL have port b  input  W  operand B, same lane packing.
REQ-009 SHALL have port op_sub  input  1  0 = A+B per lane, 1 = A-B per lane; sampled with the beat.
REQ-010 SHALL have port sat_en  input  1  1 = saturate overflowing lanes, 0 = wrap; sampled with the beat.
REQ-011 SHALL have port out_valid  output  1  result beat present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port result  output  W  per-lane result.
REQ-014 SHALL have port ovf  output  LANES  per-lane overflow flag for the current result beat.
REQ-015 SHALL have port sticky_ovf  output  LANES  per-lane OR of ovf over all delivered beats since reset/clear.
REQ-016 SHALL have port clr_sticky  input  1  clears sticky_ovf.

Function
REQ-017 SHALL accept a beat when in_valid && in_ready, and deliver it when out_valid && out_ready.
REQ-018 SHALL be a two-stage pipeline: stage 1 registers operands, op_sub and sat_en; stage 2 registers result, ovf and the valid bit.
REQ-019 SHALL use a global advance enable adv = !out_valid || out_ready; both stages load only when adv = 1; in_ready = adv.
REQ-020 SHALL move bubbles (invalid stage-1 contents) through the pipe like data; there is no bubble collapsing.
REQ-021 SHALL give a latency of exactly 2 cycles from acceptance to out_valid when out_ready stays 1, with a throughput of one beat per cycle.
REQ-022 SHALL hold result, ovf and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-023 SHALL treat each lane as independent LANE_W-bit two's complement, with no carry or borrow between lanes.
REQ-024 SHALL flag add overflow when A and B have equal sign bits and the LANE_W-bit sum sign differs from A.
REQ-025 SHALL flag subtract overflow when A and B have different sign bits and the LANE_W-bit difference sign differs from A.
REQ-026 SHALL, when sat_en = 1 and ovf[i] = 1, force lane i to the maximum 0111..1 if A[i] is non-negative, or to the minimum 1000..0 if A[i] is negative.
REQ-027 SHALL, when sat_en = 0, output the wrapped LANE_W-bit value; ovf is still reported.
REQ-028 SHALL update sticky_ovf only on a delivered beat: sticky_ovf <= sticky_ovf | ovf.
REQ-029 SHALL clear sticky_ovf to 0 on clr_sticky, except that if a beat is delivered with ovf set in the same cycle, sticky_ovf <= that beat's ovf (the set wins).

Reset
REQ-030 SHALL, on rst = 1 at a clock edge, clear both stage valid bits and set result = 0, ovf = 0, sticky_ovf = 0 and out_valid = 0.
REQ-031 SHALL drive in_ready = 1 in the first cycle after reset.
REQ-032 SHALL discard in-flight beats on reset mid-operation; no stale beat appears after reset.
REQ-033 SHALL give rst priority over clr_sticky and over handshakes.

Verification (LANE_W = 4, LANES = 4)
REQ-034 SHALL test add without overflow: a = 0x1234, b = 0x1111, op_sub = 0, sat_en = 1, out_ready = 1 -> two cycles later result = 0x2345, ovf = 0000.
REQ-035 SHALL test add with overflow and saturation: a = 0x7FFF, b = 0x1000, sat_en = 1 -> result = 0x7FFF, ovf = 1000, sticky_ovf = 1000 after delivery; repeated with sat_en = 0 -> result = 0x8FFF, ovf = 1000.
REQ-036 SHALL test subtract with negative saturation: a = 0x8000, b = 0x1001, op_sub = 1, sat_en = 1 -> result = 0x800F, ovf = 1000.
REQ-037 SHALL test backpressure: out_ready = 0 with three beats offered back to back -> two accepted, in_ready = 0 thereafter, and result holds the first beat; out_ready = 1 -> beats delivered in order, one per cycle.
REQ-038 SHALL test clear and reset: clr_sticky pulsed with an overflowing delivery -> sticky_ovf = that beat's ovf; rst asserted with two beats in flight -> out_valid = 0, sticky_ovf = 0 next cycle, and no beat emerges afterwards.
